// File: rtl/btb_set_assoc_if.sv
// Fetch/execute-side bus of the branch target buffer: flush/ready, lookup request
// and response, and the resolved-branch update channel.
interface btb_set_assoc_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            ready;
  logic            lu_valid;
  logic [XLEN-1:0] lu_pc;
  logic            lu_pred_taken;
  logic            rsp_valid;
  logic            rsp_hit;
  logic [XLEN-1:0] rsp_next_pc;
  logic            up_valid;
  logic [XLEN-1:0] up_pc;
  logic [XLEN-1:0] up_target;
  logic            up_taken;

  // Pipeline side: issues lookups/updates/flushes, consumes responses
  modport master (
    output flush, lu_valid, lu_pc, lu_pred_taken,
    output up_valid, up_pc, up_target, up_taken,
    input  ready, rsp_valid, rsp_hit, rsp_next_pc
  );

  // BTB side
  modport slave (
    input  flush, lu_valid, lu_pc, lu_pred_taken,
    input  up_valid, up_pc, up_target, up_taken,
    output ready, rsp_valid, rsp_hit, rsp_next_pc
  );
endinterface

// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer with per-entry valid bits and tree-PLRU
// replacement. Lookups respond one cycle later; updates allocate, refresh or
// invalidate entries; a sweep FSM clears valid/PLRU state after reset or flush.
module btb_set_assoc #(
  parameter int XLEN = 32,
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input logic            clk,
  input logic            rst,
  btb_set_assoc_if.slave bus
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = XLEN - IDX_W - 2;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS == 4) ? 3 : 1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  // Storage; tags and targets are never cleared, only valid bits gate them
  logic [TAG_W-1:0]  r_tag  [SETS][WAYS];
  logic [XLEN-1:0]   r_tgt  [SETS][WAYS];
  logic [WAYS-1:0]   r_vld  [SETS];
  logic [PLRU_W-1:0] r_plru [SETS];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_sweep;
  logic              w_ready;
  logic              w_clearing;

  logic              r_rsp_valid;
  logic              r_rsp_hit;
  logic [XLEN-1:0]   r_rsp_next_pc;

  // Lookup side
  logic [IDX_W-1:0]  w_lu_idx;
  logic [TAG_W-1:0]  w_lu_tag;
  logic              w_lu_hit;
  logic [WAY_W-1:0]  w_lu_way;
  logic [XLEN-1:0]   w_lu_tgt;
  logic              w_lu_fire;
  logic [XLEN-1:0]   w_lu_npc;

  // Update side
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_up_tag;
  logic              w_up_hit;
  logic [WAY_W-1:0]  w_up_way;
  logic              w_up_has_inv;
  logic [WAY_W-1:0]  w_up_inv_way;
  logic              w_up_fire;
  logic              w_up_write;
  logic              w_up_inval;
  logic [WAY_W-1:0]  w_wr_way;

  // PLRU helpers
  logic [WAY_W-1:0]  w_plru_victim;
  logic [PLRU_W-1:0] w_plru_up_new;
  logic [PLRU_W-1:0] w_plru_lu_new;

  // Low PC bits do not participate in update addressing
  logic              w_unused_up_lo;
  assign w_unused_up_lo = ^bus.up_pc[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_nxt;
  end

  // Next-state: sweep all sets, flush (re)starts the sweep
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_CLEAR: if (!bus.flush && (r_sweep == IDX_W'(SETS - 1))) w_state_nxt = S_RUN;
      S_RUN:   if (bus.flush) w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_ready    = (r_state == S_RUN);
    w_clearing = (r_state == S_CLEAR);
  end

  // Sweep counter: restarts on reset/flush, wraps to 0 when the sweep completes
  always_ff @(posedge clk) begin
    if (rst || bus.flush)  r_sweep <= '0;
    else if (w_clearing)   r_sweep <= r_sweep + IDX_W'(1);
  end

  assign w_lu_idx  = bus.lu_pc[IDX_W+1:2];
  assign w_lu_tag  = bus.lu_pc[XLEN-1:IDX_W+2];
  assign w_up_idx  = bus.up_pc[IDX_W+1:2];
  assign w_up_tag  = bus.up_pc[XLEN-1:IDX_W+2];

  assign w_lu_fire = bus.lu_valid && w_ready && !rst;
  assign w_up_fire = bus.up_valid && w_ready && !rst && !bus.flush;

  // Lookup tag compare against pre-update contents
  always_comb begin
    w_lu_hit = 1'b0;
    w_lu_way = '0;
    w_lu_tgt = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_vld[w_lu_idx][w] && (r_tag[w_lu_idx][w] == w_lu_tag)) begin
        w_lu_hit = 1'b1;
        w_lu_way = WAY_W'(w);
        w_lu_tgt = r_tgt[w_lu_idx][w];
      end
    end
  end

  assign w_lu_npc = (w_lu_hit && bus.lu_pred_taken) ? w_lu_tgt : bus.lu_pc + XLEN'(4);

  // Update tag compare and lowest-numbered invalid way search
  always_comb begin
    w_up_hit     = 1'b0;
    w_up_way     = '0;
    w_up_has_inv = 1'b0;
    w_up_inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_vld[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
        w_up_hit = 1'b1;
        w_up_way = WAY_W'(w);
      end
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!r_vld[w_up_idx][w-1]) begin
        w_up_has_inv = 1'b1;
        w_up_inv_way = WAY_W'(w - 1);
      end
    end
  end

  always_comb begin
    w_up_write = w_up_fire && bus.up_taken;
    w_up_inval = w_up_fire && !bus.up_taken && w_up_hit;
    if (w_up_hit)          w_wr_way = w_up_way;
    else if (w_up_has_inv) w_wr_way = w_up_inv_way;
    else                   w_wr_way = w_plru_victim;
  end

  // PLRU tree: each bit points towards the less recently used side
  if (WAYS == 4) begin : g_plru4
    // Victim walk and touch for the 3-bit tree
    always_comb begin
      w_plru_victim = r_plru[w_up_idx][0] ? {1'b1, r_plru[w_up_idx][2]}
                                          : {1'b0, r_plru[w_up_idx][1]};
      w_plru_up_new    = r_plru[w_up_idx];
      w_plru_up_new[0] = ~w_wr_way[1];
      if (w_wr_way[1]) w_plru_up_new[2] = ~w_wr_way[0];
      else             w_plru_up_new[1] = ~w_wr_way[0];
      w_plru_lu_new    = r_plru[w_lu_idx];
      w_plru_lu_new[0] = ~w_lu_way[1];
      if (w_lu_way[1]) w_plru_lu_new[2] = ~w_lu_way[0];
      else             w_plru_lu_new[1] = ~w_lu_way[0];
    end
  end else if (WAYS == 2) begin : g_plru2
    // Single bit names the victim way
    always_comb begin
      w_plru_victim = r_plru[w_up_idx];
      w_plru_up_new = ~w_wr_way;
      w_plru_lu_new = ~w_lu_way;
    end
  end else begin : g_plru1
    // Direct-mapped: no replacement choice
    always_comb begin
      w_plru_victim = '0;
      w_plru_up_new = '0;
      w_plru_lu_new = '0;
    end
  end

  // Valid and PLRU state: sweep clears, updates allocate/invalidate, hits touch
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_vld[r_sweep]  <= '0;
      r_plru[r_sweep] <= '0;
    end else begin
      if (w_up_write)      r_vld[w_up_idx][w_wr_way] <= 1'b1;
      else if (w_up_inval) r_vld[w_up_idx][w_up_way] <= 1'b0;
      // Update touch is issued last so it overrides a lookup touch to the same set
      if (w_lu_fire && w_lu_hit) r_plru[w_lu_idx] <= w_plru_lu_new;
      if (w_up_write)            r_plru[w_up_idx] <= w_plru_up_new;
    end
  end

  // Tag/target payload writes for taken updates
  always_ff @(posedge clk) begin
    if (w_up_write) begin
      r_tag[w_up_idx][w_wr_way] <= w_up_tag;
      r_tgt[w_up_idx][w_wr_way] <= bus.up_target;
    end
  end

  // Registered lookup response; hit/next_pc hold when no response is produced
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_hit     <= 1'b0;
      r_rsp_next_pc <= '0;
    end else if (w_lu_fire) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_hit     <= w_lu_hit;
      r_rsp_next_pc <= w_lu_npc;
    end else begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign bus.ready       = w_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_hit     = r_rsp_hit;
  assign bus.rsp_next_pc = r_rsp_next_pc;

endmodule

// File: tb/tb_btb_set_assoc.sv
// Bench for btb_set_assoc: directed scenarios plus randomized traffic against a
// recency-based reference model of the buffer.
module tb_btb_set_assoc;

  localparam int XLEN  = 32;
  localparam int SETS  = 64;
  localparam int WAYS  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btb_set_assoc_if #(.XLEN(XLEN)) bus ();

  btb_set_assoc #(.XLEN(XLEN), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-set entries plus most-recently-used way
  bit          m_vld [SETS][WAYS];
  logic [31:0] m_tag [SETS][WAYS];
  logic [31:0] m_tgt [SETS][WAYS];
  int          m_mru [SETS];
  int          m_busy;
  bit          m_rv;
  bit          m_rh;
  logic [31:0] m_rn;

  function automatic int set_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> 8;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
      m_mru[s] = 1;  // cleared PLRU names way 0 as victim
    end
    m_busy = SETS;
  endtask

  task automatic model_step();
    bit pre_ready;
    int ls, us, hw, lu_touch, up_touch, way;
    pre_ready = (m_busy == 0);
    lu_touch  = -1;
    up_touch  = -1;
    ls = set_of(bus.lu_pc);
    us = set_of(bus.up_pc);
    if (rst) begin
      model_clear();
      m_rv = 0; m_rh = 0; m_rn = '0;
      return;
    end
    if (bus.lu_valid && pre_ready) begin
      hw = -1;
      for (int w = 0; w < WAYS; w++)
        if (m_vld[ls][w] && m_tag[ls][w] == tag_of(bus.lu_pc)) hw = w;
      m_rv = 1;
      m_rh = (hw >= 0);
      m_rn = (hw >= 0 && bus.lu_pred_taken) ? m_tgt[ls][hw] : bus.lu_pc + 32'd4;
      lu_touch = hw;
    end else begin
      m_rv = 0;
    end
    if (bus.up_valid && pre_ready && !bus.flush) begin
      hw = -1;
      for (int w = 0; w < WAYS; w++)
        if (m_vld[us][w] && m_tag[us][w] == tag_of(bus.up_pc)) hw = w;
      if (bus.up_taken) begin
        if (hw >= 0) way = hw;
        else begin
          way = -1;
          for (int w = WAYS - 1; w >= 0; w--) if (!m_vld[us][w]) way = w;
          if (way < 0) way = (m_mru[us] == 0) ? 1 : 0;
        end
        m_vld[us][way] = 1'b1;
        m_tag[us][way] = tag_of(bus.up_pc);
        m_tgt[us][way] = bus.up_target;
        up_touch = way;
      end else if (hw >= 0) begin
        m_vld[us][hw] = 1'b0;
      end
    end
    if (lu_touch >= 0 && !(up_touch >= 0 && us == ls)) m_mru[ls] = lu_touch;
    if (up_touch >= 0) m_mru[us] = up_touch;
    if (bus.flush) model_clear();
    else if (m_busy > 0) m_busy--;
  endtask

  // One clock: inputs already driven, advance the model, then return strobes to idle
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    bus.lu_valid = 1'b0;
    bus.up_valid = 1'b0;
    bus.flush    = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic drive_up(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
    bus.up_valid  = 1'b1;
    bus.up_pc     = pc;
    bus.up_target = tgt;
    bus.up_taken  = taken;
  endtask

  task automatic drive_lu(input logic [31:0] pc, input bit pred);
    bus.lu_valid      = 1'b1;
    bus.lu_pc         = pc;
    bus.lu_pred_taken = pred;
  endtask

  task automatic do_flush();
    int n;
    bus.flush = 1'b1;
    tick();
    wait_ready(n);
    n_vec++;
    if (n !== SETS) begin n_err++; $display("FAIL flush_len: ready low %0d cycles, want %0d", n, SETS); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_hit !== 1'b0 || bus.rsp_next_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rsp: got v=%0b h=%0b pc=%h, want 0 0 0", bus.rsp_valid, bus.rsp_hit, bus.rsp_next_pc);
    end
    for (int i = 0; i < SETS; i++) begin
      n_vec++;
      if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low: cycle %0d got %0b want 0", i, bus.ready); end
      if (i == 11) begin
        n_vec++;
        if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL sweep_lookup: rsp_valid %0b want 0", bus.rsp_valid); end
      end
      if (i == 10) drive_lu(32'h0000_0100, 1'b1);
      tick();
    end
    n_vec++;
    if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_high: got %0b want 1", bus.ready); end
  endtask

  task automatic test_hit_target();
    drive_up(32'h0000_1000, 32'h0000_2000, 1'b1);
    tick();
    drive_lu(32'h0000_1000, 1'b1);
    tick();
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b1 || bus.rsp_next_pc !== 32'h0000_2000) begin
      n_err++;
      $display("FAIL hit_taken: got v=%0b h=%0b pc=%h, want 1 1 00002000", bus.rsp_valid, bus.rsp_hit, bus.rsp_next_pc);
    end
    drive_lu(32'h0000_1000, 1'b0);
    tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b1 || bus.rsp_next_pc !== 32'h0000_1004) begin
      n_err++;
      $display("FAIL hit_not_taken: got h=%0b pc=%h, want 1 00001004", bus.rsp_hit, bus.rsp_next_pc);
    end
    tick();
    n_vec++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_next_pc !== 32'h0000_1004) begin
      n_err++;
      $display("FAIL rsp_hold: got v=%0b pc=%h, want 0 00001004", bus.rsp_valid, bus.rsp_next_pc);
    end
  endtask

  task automatic test_plru_evict();
    do_flush();
    drive_up(32'h0000_1000, 32'h0000_A000, 1'b1); tick();
    drive_up(32'h0000_2000, 32'h0000_B000, 1'b1); tick();
    drive_lu(32'h0000_1000, 1'b1); tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b1 || bus.rsp_next_pc !== 32'h0000_A000) begin
      n_err++; $display("FAIL plru_touch: got h=%0b pc=%h, want 1 0000a000", bus.rsp_hit, bus.rsp_next_pc);
    end
    drive_up(32'h0000_3000, 32'h0000_C000, 1'b1); tick();
    drive_lu(32'h0000_2000, 1'b1); tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b0 || bus.rsp_next_pc !== 32'h0000_2004) begin
      n_err++; $display("FAIL plru_evicted: got h=%0b pc=%h, want 0 00002004", bus.rsp_hit, bus.rsp_next_pc);
    end
    drive_lu(32'h0000_1000, 1'b1); tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b1 || bus.rsp_next_pc !== 32'h0000_A000) begin
      n_err++; $display("FAIL plru_kept: got h=%0b pc=%h, want 1 0000a000", bus.rsp_hit, bus.rsp_next_pc);
    end
    drive_lu(32'h0000_3000, 1'b1); tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b1 || bus.rsp_next_pc !== 32'h0000_C000) begin
      n_err++; $display("FAIL plru_new: got h=%0b pc=%h, want 1 0000c000", bus.rsp_hit, bus.rsp_next_pc);
    end
  endtask

  task automatic test_invalidate();
    do_flush();
    drive_up(32'h0000_1000, 32'h0000_2000, 1'b1); tick();
    drive_up(32'h0000_1000, 32'h0000_2000, 1'b0); tick();
    drive_lu(32'h0000_1000, 1'b1); tick();
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b0 || bus.rsp_next_pc !== 32'h0000_1004) begin
      n_err++; $display("FAIL invalidate: got v=%0b h=%0b pc=%h, want 1 0 00001004", bus.rsp_valid, bus.rsp_hit, bus.rsp_next_pc);
    end
  endtask

  task automatic test_same_cycle();
    do_flush();
    drive_up(32'h0000_1000, 32'h0000_7770, 1'b1);
    drive_lu(32'h0000_1000, 1'b1);
    tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b0 || bus.rsp_next_pc !== 32'h0000_1004) begin
      n_err++; $display("FAIL rbw_same: got h=%0b pc=%h, want 0 00001004", bus.rsp_hit, bus.rsp_next_pc);
    end
    drive_lu(32'h0000_1000, 1'b1); tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b1 || bus.rsp_next_pc !== 32'h0000_7770) begin
      n_err++; $display("FAIL rbw_next: got h=%0b pc=%h, want 1 00007770", bus.rsp_hit, bus.rsp_next_pc);
    end
  endtask

  task automatic test_wrap_flush();
    int n;
    drive_lu(32'hFFFF_FFFC, 1'b1); tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b0 || bus.rsp_next_pc !== 32'h0000_0000) begin
      n_err++; $display("FAIL wrap: got h=%0b pc=%h, want 0 00000000", bus.rsp_hit, bus.rsp_next_pc);
    end
    drive_up(32'h0000_4004, 32'h0000_9000, 1'b1); tick();
    // flush together with an update: the update must be dropped
    bus.flush = 1'b1;
    drive_up(32'h0000_5008, 32'h0000_9100, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) tick();
    // flush during the sweep restarts it from set 0
    bus.flush = 1'b1;
    tick();
    wait_ready(n);
    n_vec++;
    if (n !== SETS) begin n_err++; $display("FAIL flush_restart: ready low %0d cycles, want %0d", n, SETS); end
    drive_lu(32'h0000_4004, 1'b1); tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b0 || bus.rsp_next_pc !== 32'h0000_4008) begin
      n_err++; $display("FAIL flush_miss: got h=%0b pc=%h, want 0 00004008", bus.rsp_hit, bus.rsp_next_pc);
    end
    drive_lu(32'h0000_5008, 1'b1); tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b0) begin n_err++; $display("FAIL flush_drop_update: got h=%0b want 0", bus.rsp_hit); end
    drive_lu(32'h0000_3000, 1'b1); tick();
    n_vec++;
    if (bus.rsp_hit !== 1'b0) begin n_err++; $display("FAIL flush_old_entry: got h=%0b want 0", bus.rsp_hit); end
  endtask

  task automatic test_random();
    logic [23:0] tags [4];
    logic [31:0] pc;
    tags[0] = 24'h000010; tags[1] = 24'h000020; tags[2] = 24'hABCDEF; tags[3] = 24'hFFFFFF;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        pc = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        drive_lu(pc, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 1) == 1) begin
        pc = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        drive_up(pc, $urandom, ($urandom_range(0, 3) != 0));
      end
      if ($urandom_range(0, 149) == 0) bus.flush = 1'b1;
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      tick();
      n_vec++;
      if (bus.ready !== (m_busy == 0)) begin n_err++; $display("FAIL rnd_ready: cycle %0d got %0b want %0b", i, bus.ready, (m_busy == 0)); end
      n_vec++;
      if (bus.rsp_valid !== m_rv) begin n_err++; $display("FAIL rnd_valid: cycle %0d got %0b want %0b", i, bus.rsp_valid, m_rv); end
      n_vec++;
      if (bus.rsp_hit !== m_rh) begin n_err++; $display("FAIL rnd_hit: cycle %0d got %0b want %0b", i, bus.rsp_hit, m_rh); end
      n_vec++;
      if (bus.rsp_next_pc !== m_rn) begin n_err++; $display("FAIL rnd_next_pc: cycle %0d got %h want %h", i, bus.rsp_next_pc, m_rn); end
    end
  endtask

  initial begin
    bus.flush = 1'b0; bus.lu_valid = 1'b0; bus.lu_pc = '0; bus.lu_pred_taken = 1'b0;
    bus.up_valid = 1'b0; bus.up_pc = '0; bus.up_target = '0; bus.up_taken = 1'b0;
    m_rv = 0; m_rh = 0; m_rn = '0;
    model_clear();
    test_reset();
    test_hit_target();
    test_plru_evict();
    test_invalidate();
    test_same_cycle();
    test_wrap_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
